// File: rtl/text_term_ctrl.sv
// -----------------------------------------------------------------------------
// text_term_ctrl
//
// Character-terminal write controller for the 70x30 text buffer read by the VGA
// font renderer. It is the only writer of that buffer. Bytes arrive over a
// valid/ready handshake, and the controller keeps the cursor position. It
// handles line wrap, newline (LF/CR), backspace, form feed and scrolling.
// Scrolling is done by rotating a ring-buffer top-row offset and clearing the
// row that was on top. The display side reads top_row to rotate rows on screen.
//
// Handshake: a byte transfers on any rising clk edge where in_valid && in_ready.
// in_ready is high only in IDLE. While it is low the source must hold in_valid
// and in_ascii steady; nothing is consumed until in_ready returns.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset (restarts the screen fill)
//   in_valid   in   byte available
//   in_ascii   in   ASCII byte
//   in_ready   out  controller accepts a byte this cycle (IDLE and not in reset)
//   mem_we     out  text-buffer write strobe
//   mem_waddr  out  {col[6:0], phys_row[4:0]}
//   mem_wdata  out  character to write
//   cur_col    out  cursor column 0..COLS-1
//   cur_row    out  cursor logical row 0..ROWS-1
//   top_row    out  physical row shown as screen line 0
//   busy       out  high in any state other than IDLE
//   dbg_state  out  current FSM state (FILL=0, IDLE=1, WRITE=2, CLEAR=3)
// -----------------------------------------------------------------------------
module text_term_ctrl #(
    parameter int         COLS     = 70,
    parameter int         ROWS     = 30,
    parameter logic [7:0] CLR_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_ascii,
    output logic        in_ready,
    output logic        mem_we,
    output logic [11:0] mem_waddr,
    output logic [7:0]  mem_wdata,
    output logic [6:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic [4:0]  top_row,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WRITE = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    // (top + row) mod ROWS without a divider: both operands are < ROWS, so one
    // conditional subtract is enough.
    function automatic logic [4:0] phys_row(input logic [4:0] top, input logic [4:0] row);
        logic [5:0] sum;
        sum = {1'b0, top} + {1'b0, row};
        if (sum >= 6'(ROWS)) begin
            sum = sum - 6'(ROWS);
        end
        return sum[4:0];
    endfunction

    state_t      r_state;
    logic        r_busy;
    logic [6:0]  r_col;
    logic [4:0]  r_row;
    logic [4:0]  r_top;
    logic        r_we;
    logic [11:0] r_waddr;
    logic [7:0]  r_wdata;
    logic [6:0]  r_cnt_col;   // next column to clear in FILL/CLEAR
    logic [4:0]  r_cnt_row;   // next row to clear in FILL
    logic [4:0]  r_clr_row;   // physical row wiped by CLEAR
    logic        r_scroll;    // WRITE must be followed by CLEAR

    logic        w_is_print;
    logic        w_is_nl;
    logic        w_is_bs;
    logic        w_is_ff;
    logic        w_at_last_col;
    logic        w_at_last_row;
    logic        w_do_nl;
    logic        w_bs_moves;
    logic [6:0]  w_bs_col;
    logic [4:0]  w_bs_row;
    logic [4:0]  w_phys_cur;
    logic [4:0]  w_phys_bs;
    logic [4:0]  w_top_next;

    always_comb begin
        w_is_print    = (in_ascii >= 8'h20) && (in_ascii <= 8'h7E);
        w_is_nl       = (in_ascii == 8'h0A) || (in_ascii == 8'h0D);
        w_is_bs       = (in_ascii == 8'h08);
        w_is_ff       = (in_ascii == 8'h0C);
        w_at_last_col = (r_col == LAST_COL);
        w_at_last_row = (r_row == LAST_ROW);
        // A printable in the last column wraps exactly like a newline.
        w_do_nl       = w_is_nl || (w_is_print && w_at_last_col);
        w_bs_moves    = (r_col != 7'd0) || (r_row != 5'd0);
        w_bs_col      = (r_col != 7'd0) ? (r_col - 7'd1) : LAST_COL;
        w_bs_row      = (r_col != 7'd0) ? r_row : (r_row - 5'd1);
        w_phys_cur    = phys_row(r_top, r_row);
        w_phys_bs     = phys_row(r_top, w_bs_row);
        w_top_next    = (r_top == LAST_ROW) ? 5'd0 : (r_top + 5'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FILL;
            r_busy    <= 1'b1;
            r_col     <= 7'd0;
            r_row     <= 5'd0;
            r_top     <= 5'd0;
            r_we      <= 1'b0;
            r_waddr   <= 12'd0;
            r_wdata   <= CLR_CHAR;
            r_cnt_col <= 7'd0;
            r_cnt_row <= 5'd0;
            r_clr_row <= 5'd0;
            r_scroll  <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    // The FILL state is always entered with r_we low, so seeing
                    // the last cell registered means the final write is on the
                    // bus now.
                    if (r_we && (r_waddr == {LAST_COL, LAST_ROW})) begin
                        r_we      <= 1'b0;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_col     <= 7'd0;
                        r_row     <= 5'd0;
                        r_top     <= 5'd0;
                        r_cnt_col <= 7'd0;
                        r_cnt_row <= 5'd0;
                    end else begin
                        r_we    <= 1'b1;
                        r_waddr <= {r_cnt_col, r_cnt_row};
                        r_wdata <= CLR_CHAR;
                        if (r_cnt_col == LAST_COL) begin
                            r_cnt_col <= 7'd0;
                            r_cnt_row <= r_cnt_row + 5'd1;
                        end else begin
                            r_cnt_col <= r_cnt_col + 7'd1;
                        end
                    end
                end

                ST_IDLE: begin
                    r_we <= 1'b0;
                    if (in_valid) begin
                        if (w_is_print) begin
                            r_we    <= 1'b1;
                            r_waddr <= {r_col, w_phys_cur};
                            r_wdata <= in_ascii;
                            if (!w_at_last_col) begin
                                r_col <= r_col + 7'd1;
                            end
                        end
                        if (w_do_nl) begin
                            r_col <= 7'd0;
                            if (!w_at_last_row) begin
                                r_row <= r_row + 5'd1;
                            end else begin
                                r_clr_row <= r_top;
                                r_top     <= w_top_next;
                            end
                        end
                        r_scroll <= w_do_nl && w_at_last_row;
                        if (w_is_bs && w_bs_moves) begin
                            r_col   <= w_bs_col;
                            r_row   <= w_bs_row;
                            r_we    <= 1'b1;
                            r_waddr <= {w_bs_col, w_phys_bs};
                            r_wdata <= CLR_CHAR;
                        end

                        if (w_is_ff) begin
                            r_state   <= ST_FILL;
                            r_busy    <= 1'b1;
                            r_col     <= 7'd0;
                            r_row     <= 5'd0;
                            r_top     <= 5'd0;
                            r_cnt_col <= 7'd0;
                            r_cnt_row <= 5'd0;
                        end else if (w_is_print || w_is_nl || w_is_bs) begin
                            r_state <= ST_WRITE;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    if (r_scroll) begin
                        // First clear write goes out in the first CLEAR cycle.
                        r_state   <= ST_CLEAR;
                        r_scroll  <= 1'b0;
                        r_we      <= 1'b1;
                        r_waddr   <= {7'd0, r_clr_row};
                        r_wdata   <= CLR_CHAR;
                        r_cnt_col <= 7'd1;
                    end else begin
                        r_we    <= 1'b0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_CLEAR: begin
                    if (r_waddr[11:5] == LAST_COL) begin
                        r_we      <= 1'b0;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_cnt_col <= 7'd0;
                    end else begin
                        r_we      <= 1'b1;
                        r_waddr   <= {r_cnt_col, r_clr_row};
                        r_wdata   <= CLR_CHAR;
                        r_cnt_col <= r_cnt_col + 7'd1;
                    end
                end

                default: begin
                    r_state <= ST_FILL;
                    r_busy  <= 1'b1;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign mem_we    = r_we;
    assign mem_waddr = r_waddr;
    assign mem_wdata = r_wdata;
    assign cur_col   = r_col;
    assign cur_row   = r_row;
    assign top_row   = r_top;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_text_term_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for text_term_ctrl. Stimulus tasks push the expected text-buffer writes
// ({addr, data}) into exp_q. A monitor pops one entry for every mem_we cycle
// and compares it. Cursor, top_row and handshake values are checked directly
// by the stimulus process.
// -----------------------------------------------------------------------------
module tb_text_term_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_ascii;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic [4:0]  top_row;
    logic        busy;
    logic [1:0]  dbg_state;

    logic [19:0] exp_q[$];
    int          n_cmp;
    int          n_bad;

    text_term_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ascii  (in_ascii),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .top_row   (top_row),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         mem_waddr, mem_wdata);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({mem_waddr, mem_wdata} !== e) begin
                    n_bad++;
                    $display("FAIL mem_write: got col=%0d row=%0d data=%h, required col=%0d row=%0d data=%h",
                             mem_waddr[11:5], mem_waddr[4:0], mem_wdata,
                             e[19:13], e[12:8], e[7:0]);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [19:0] wr(input int col, input int row, input logic [7:0] d);
        logic [6:0] c;
        logic [4:0] r;
        c = 7'(col);
        r = 5'(row);
        return {c, r, d};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic push_fill();
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 70; c++) begin
                exp_q.push_back(wr(c, r, 8'h20));
            end
        end
    endtask

    task automatic push_clear(input int row);
        for (int c = 0; c < 70; c++) begin
            exp_q.push_back(wr(c, row, 8'h20));
        end
    endtask

    // Called at a negedge. Returns at the negedge right after the accept edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        in_valid = 1'b1;
        in_ascii = b;
        t = 0;
        while (!in_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", t);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!in_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got in_ready=0 after %0d cycles, required 1", t);
        end
    endtask

    task automatic send_idle(input logic [7:0] b);
        send_byte(b);
        wait_idle();
    endtask

    // Measures the contiguous mem_we burst of a screen fill.
    task automatic measure_fill(input string tag);
        int t;
        int cnt;
        t = 0;
        while (!mem_we && t < 10) begin
            @(negedge clk);
            t++;
        end
        cnt = 0;
        while (mem_we && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, "_fill_len"}, cnt, 2100);
        check({tag, "_ready_after_fill"}, in_ready, 1);
        check({tag, "_cur_col"}, cur_col, 0);
        check({tag, "_cur_row"}, cur_row, 0);
        check({tag, "_top_row"}, top_row, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_ascii = 8'h00;

        // Reset state
        @(negedge clk);
        check("rst_cur_col", cur_col, 0);
        check("rst_cur_row", cur_row, 0);
        check("rst_top_row", top_row, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_waddr", mem_waddr, 0);
        check("rst_mem_wdata", mem_wdata, 8'h20);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_state_fill", dbg_state, 0);

        // Power-up fill
        push_fill();
        rst = 1'b0;
        measure_fill("boot");
        check("boot_busy_low", busy, 0);

        // Single printable: write at (0,0), cursor advances, ready low 1 cycle
        exp_q.push_back(wr(0, 0, 8'h41));
        send_byte(8'h41);
        check("a_cur_col", cur_col, 1);
        check("a_ready_low", in_ready, 0);
        @(negedge clk);
        check("a_ready_back", in_ready, 1);

        // Backspace from (1,0) back to (0,0) clears that cell
        exp_q.push_back(wr(0, 0, 8'h20));
        send_idle(8'h08);
        check("bs1_cur_col", cur_col, 0);

        // 70 printables fill row 0 and wrap to (0,1) without a scroll
        for (int i = 0; i < 70; i++) begin
            exp_q.push_back(wr(i, 0, 8'h42));
            send_byte(8'h42);
            if (i != 69) wait_idle();
        end
        check("wrap_cur_col", cur_col, 0);
        check("wrap_cur_row", cur_row, 1);
        check("wrap_top_row", top_row, 0);
        @(negedge clk);
        check("wrap_no_clear_ready", in_ready, 1);

        // Backspace at column 0 moves up to (69,0)
        exp_q.push_back(wr(69, 0, 8'h20));
        send_idle(8'h08);
        check("bs2_cur_col", cur_col, 69);
        check("bs2_cur_row", cur_row, 0);

        // Ignored control byte: consumed, no state change, no write
        send_idle(8'h07);
        check("ign_cur_col", cur_col, 69);

        // Form feed: full fill, home cursor
        send_byte(8'h0C);
        check("ff_busy", busy, 1);
        push_fill();
        measure_fill("ff");

        // Backspace at (0,0): no move, no write
        send_idle(8'h08);
        check("bs00_cur_col", cur_col, 0);
        check("bs00_cur_row", cur_row, 0);

        // Walk down to row 29 and write 5 characters
        for (int i = 0; i < 29; i++) send_idle(8'h0A);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(wr(i, 29, 8'(8'h61 + i)));
            send_idle(8'(8'h61 + i));
        end
        check("pos_cur_col", cur_col, 5);
        check("pos_cur_row", cur_row, 29);
        check("pos_top_row", top_row, 0);

        // CR on last row: scroll, clear old top row 0, busy for WRITE+70
        push_clear(0);
        send_byte(8'h0D);
        check("scr_top_row", top_row, 1);
        check("scr_cur_col", cur_col, 0);
        check("scr_cur_row", cur_row, 29);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("scr_busy_cycles", cnt, 71);
        check("scr_ready", in_ready, 1);

        // Next char lands at phys (1+29) mod 30 = 0
        exp_q.push_back(wr(0, 0, 8'h43));
        send_idle(8'h43);
        check("c_cur_col", cur_col, 1);

        // Fill to the last cell: write lands at (69, phys 0), then scroll
        for (int i = 1; i < 70; i++) exp_q.push_back(wr(i, 0, 8'h44));
        push_clear(1);
        for (int i = 1; i < 70; i++) send_idle(8'h44);
        check("last_top_row", top_row, 2);
        check("last_cur_col", cur_col, 0);
        check("last_cur_row", cur_row, 29);

        // 28 more scrolls: top_row wraps 29 -> 0
        for (int k = 2; k < 30; k++) begin
            push_clear(k);
            send_idle(8'h0A);
        end
        check("wrap_top_zero", top_row, 0);
        exp_q.push_back(wr(0, 29, 8'h45));
        send_idle(8'h45);

        // Two backspaces: (1,29)->(0,29)->(69,28)
        exp_q.push_back(wr(0, 29, 8'h20));
        send_idle(8'h08);
        exp_q.push_back(wr(69, 28, 8'h20));
        send_idle(8'h08);
        check("bs3_cur_col", cur_col, 69);
        check("bs3_cur_row", cur_row, 28);

        // Reset in the middle of CLEAR with a held byte
        send_idle(8'h0A);
        for (int i = 0; i < 10; i++) exp_q.push_back(wr(i, 0, 8'h20));
        send_byte(8'h0A);
        check("mid_top_row", top_row, 1);
        for (int i = 0; i < 10; i++) @(negedge clk);
        in_valid = 1'b1;
        in_ascii = 8'h46;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_mem_we", mem_we, 0);
        check("mid_rst_top_row", top_row, 0);
        check("mid_rst_cur_row", cur_row, 0);
        check("mid_rst_in_ready", in_ready, 0);
        push_fill();
        @(negedge clk);
        rst = 1'b0;
        measure_fill("mid");
        exp_q.push_back(wr(0, 0, 8'h46));
        @(negedge clk);
        in_valid = 1'b0;
        check("held_cur_col", cur_col, 1);
        wait_idle();
        repeat (3) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/text_term_ctrl.md
Name: text_term_ctrl

Overview:
- Character-terminal write controller for the 70x30 text buffer that the VGA font renderer reads.
- Accepts ASCII bytes over a valid/ready handshake, typically from PS/2 keyboard decode.
- Maintains the cursor and handles wrap, newline, backspace, form feed and hardware scrolling, using a ring-buffer top-row offset and row clearing.
- Is the sole writer of the text buffer. The display side reads top_row to rotate rows.

Parameters:
- COLS, 70, characters per row (max 64+ fits in 6-bit col index; 70 needs 7 bits, so col fields are 7 bits).
- ROWS, 30, rows on screen.
- CLR_CHAR, 8'h20, fill character for cleared cells.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  byte available
- in_ascii  in  8  ASCII byte
- in_ready  out  1  controller can accept a byte this cycle
- mem_we  out  1  text-buffer write strobe
- mem_waddr  out  12  {col[6:0], phys_row[4:0]}
- mem_wdata  out  8  character to write
- cur_col  out  7  cursor column, 0..COLS-1
- cur_row  out  5  cursor logical row, 0..ROWS-1
- top_row  out  5  physical row shown as screen line 0
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high.
- Reset values: cur_col=0, cur_row=0, top_row=0, mem_we=0, mem_waddr=0, mem_wdata=CLR_CHAR. State is FILL.
- Registered outputs: all outputs are registered except in_ready. in_ready = (state==IDLE) && !rst.
- Physical row: phys_row = (top_row + cur_row) mod ROWS. Computed without a divider (compare against ROWS, subtract).

States:
- FILL: writes CLR_CHAR to every cell, one per cycle, row 0..ROWS-1 outer, col 0..COLS-1 inner. mem_we=1 for exactly COLS*ROWS = 2100 cycles. Then goes to IDLE with cursor (0,0) and top_row=0.
- IDLE: in_ready=1. A byte is accepted when in_valid && in_ready. in_ascii is captured. Next state is WRITE, or IDLE for ignored bytes.
- WRITE: one cycle. mem_we=1 only if the accepted byte requires a write (see decode). Then goes to IDLE, or to CLEAR if a scroll was triggered.
- CLEAR: writes CLR_CHAR to all COLS cells of physical row clr_row, one per cycle (COLS cycles, mem_we=1). Then goes to IDLE.

Byte decode (evaluated on the accept cycle; cursor updates visible the cycle after accept):
- 0x20..0x7E (printable): write at the current cursor position, then advance.
  - If cur_col==COLS-1, apply the newline action.
  - Otherwise cur_col++.
- 0x0A or 0x0D (newline): cur_col=0.
  - If cur_row<ROWS-1: cur_row++.
  - Otherwise scroll: clr_row=top_row (old), top_row=(top_row+1) mod ROWS, cur_row stays ROWS-1, go to CLEAR after WRITE.
  - No character write for newline; WRITE has mem_we=0.
- 0x08 (backspace):
  - If cur_col>0: cur_col--.
  - Else if cur_row>0: cur_row--, cur_col=COLS-1.
  - The new position is written with CLR_CHAR.
  - At (0,0): no move and no write. Backspace never un-scrolls.
- 0x0C (form feed): go to FILL (full 2100-cycle clear), then cursor (0,0), top_row=0.
- Any other byte: consumed, no effect, stays IDLE.

Latency, throughput and boundaries:
- Printable byte accepted in cycle N: mem_we=1 in cycle N+1, using the pre-advance cursor address. in_ready returns in cycle N+2. Maximum rate is one byte per 2 cycles.
- A printable in the last cell (COLS-1, ROWS-1): the write lands there, then scroll. Cursor becomes (0, ROWS-1) and the next COLS cycles clear the old top physical row.
- top_row wraps ROWS-1 -> 0.
- in_valid while busy: the byte is not consumed. The source must hold in_valid and in_ascii until in_ready.
- rst mid-FILL, mid-CLEAR or mid-WRITE: everything returns to reset values immediately and FILL restarts from cell 0. An in-flight byte is lost.
- mem_waddr and mem_wdata are don't-care when mem_we=0, but must be stable during mem_we=1.

Test Plan:
- Release rst: mem_we high for exactly 2100 consecutive cycles, all data 0x20, last addr {7'd69,5'd29}. in_ready rises the next cycle.
- After FILL, send 0x41: one mem_we pulse, addr {7'd0,5'd0}, data 0x41. cur_col=1, and in_ready is low for 1 cycle.
- Send 70 x 0x42 from (0,0): last write at {7'd69,5'd0}. Cursor (0,1), no CLEAR.
- Cursor at (5,29), top_row=0, send 0x0D: no char write. top_row=1, cursor (0,29), then 70 writes of 0x20 to phys row 0, busy high throughout. A subsequent 0x43 writes at {7'd0,5'd0} (phys (1+29) mod 30).
- Cursor (0,1), send 0x08: cursor (69,0), one write of 0x20 at {7'd69, phys_row}. A further 0x08 at (0,0) produces no write.
- Assert rst during CLEAR with in_valid held: outputs reset at once. FILL restarts at addr 0 and the held byte is accepted only after the 2100-cycle fill.
